muldiv_unit: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the combinational ALU in the execute stage and is generalised to XLEN-bit operands. It adds valid/ready handshakes, an iterative datapath, a fast path for special divide cases, and flush support. The core stalls on ready_o/valid_o while an M-extension instruction is in flight.

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes and flush.
// Shift-add multiply and restoring divide run on operand magnitudes; the sign is applied once at the end.
module muldiv_unit #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned     CW       = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic              r_neg, r_fast;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a, r_b, r_rem, r_result;
  logic [2*XLEN-1:0] r_acc;

  logic              w_accept, w_signed_a, w_signed_b, w_sa, w_sb;
  logic              w_div0, w_ovf, w_special, w_neg, w_last;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
  logic [XLEN-1:0]   w_mul_res, w_div_sel, w_div_res;
  logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept   = (r_state == S_IDLE) && valid_i && !flush_i;
  assign w_signed_a = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_signed_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
  assign w_sa       = w_signed_a && operand_a_i[XLEN-1];
  assign w_sb       = w_signed_b && operand_b_i[XLEN-1];
  assign w_a_mag    = w_sa ? -operand_a_i : operand_a_i;
  assign w_b_mag    = w_sb ? -operand_b_i : operand_b_i;
  assign w_div0     = (operand_b_i == '0);
  assign w_ovf      = ((op_i == 3'b100) || (op_i == 3'b110)) &&
                      (operand_a_i == MOST_NEG) && (operand_b_i == '1);
  assign w_special  = op_i[2] && (w_div0 || w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_div0) w_special_res = op_i[1] ? operand_a_i : '1;
    else        w_special_res = op_i[1] ? '0 : MOST_NEG;
  end

  // A zero divisor yields an all-ones quotient magnitude, so the quotient sign is suppressed there
  always_comb begin
    w_neg = 1'b0;
    case (op_i)
      3'b001:  w_neg = w_sa ^ w_sb;
      3'b010:  w_neg = w_sa;
      3'b100:  w_neg = (w_sa ^ w_sb) && !w_div0;
      3'b110:  w_neg = w_sa;
      default: w_neg = 1'b0;
    endcase
  end

  assign w_last    = (r_cnt == CW'(XLEN));
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_rem_sh  = {r_rem, r_acc[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_sel = r_op[1] ? r_rem : r_acc[XLEN-1:0];
  assign w_div_res = r_neg ? -w_div_sel : w_div_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b1;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (w_accept) w_next = op_i[2] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        if (flush_i)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DIV: begin
        if (flush_i)               w_next = S_IDLE;
        else if (r_fast || w_last) w_next = S_DONE;
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (flush_i || ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply keeps the multiplier in the low half of r_acc; divide shifts the dividend out of it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_fast   <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= op_i[1:0];
      r_neg  <= w_neg;
      r_fast <= FAST_SPECIAL && w_special;
      r_cnt  <= '0;
      r_a    <= w_a_mag;
      r_b    <= w_b_mag;
      r_rem  <= '0;
      r_acc  <= {{XLEN{1'b0}}, (op_i[2] ? w_a_mag : w_b_mag)};
      if (FAST_SPECIAL && w_special) r_result <= w_special_res;
    end else if ((r_state == S_MUL || r_state == S_DIV) && !r_fast) begin
      if (!w_last) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_state == S_MUL) begin
          r_acc <= {w_sum, r_acc[XLEN-1:1]};
        end else begin
          r_acc[XLEN-1:0] <= {r_acc[XLEN-2:0], !w_diff[XLEN]};
          r_rem           <= w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        end
      end else begin
        r_result <= (r_state == S_MUL) ? w_mul_res : w_div_res;
      end
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: XLEN=32 with fast specials and XLEN=8 with iterated specials,
// directed cases plus randomised sweeps against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, rst_n;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush, rdy, v32, v8;
  logic        rdyo32, vo32, busy32, rdyo8, vo8, busy8;
  logic [31:0] res32;
  logic [7:0]  res8;
  int          n_chk, n_err;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v32), .ready_o(rdyo32), .op_i(op),
    .operand_a_i(a), .operand_b_i(b), .flush_i(flush), .valid_o(vo32),
    .ready_i(rdy), .result_o(res32), .busy_o(busy32)
  );

  muldiv_unit #(.XLEN(8), .FAST_SPECIAL(1'b0)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .ready_o(rdyo8), .op_i(op),
    .operand_a_i(a[7:0]), .operand_b_i(b[7:0]), .flush_i(flush), .valid_o(vo8),
    .ready_i(rdy), .result_o(res8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input int w, input logic [2:0] o,
                                         input logic [63:0] ia, input logic [63:0] ib);
    logic [63:0] mask, ua, ub, pu;
    longint      sa, sb, mn, p;
    mask = (64'd1 << w) - 64'd1;
    ua   = ia & mask;
    ub   = ib & mask;
    sa   = ia[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = ib[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    mn   = -(longint'(1) << (w - 1));
    case (o)
      3'd0: begin p = sa * sb;            return 64'(p) & mask; end
      3'd1: begin p = sa * sb;            return 64'(p >>> w) & mask; end
      3'd2: begin p = sa * longint'(ub);  return 64'(p >>> w) & mask; end
      3'd3: begin pu = ua * ub;           return (pu >> w) & mask; end
      3'd4: begin
        if (ub == 0)                return mask;
        if (sa == mn && sb == -1)   return ua;
        return 64'(sa / sb) & mask;
      end
      3'd5: return (ub == 0) ? mask : (ua / ub);
      3'd6: begin
        if (ub == 0)                return ua;
        if (sa == mn && sb == -1)   return 64'd0;
        return 64'(sa % sb) & mask;
      end
      default: return (ub == 0) ? ua : (ua % ub);
    endcase
  endfunction

  function automatic logic cur_vo(input bit s8);
    return s8 ? vo8 : vo32;
  endfunction

  function automatic logic [31:0] cur_res(input bit s8);
    return s8 ? {24'd0, res8} : res32;
  endfunction

  // hold < 0: random ready_i; otherwise ready_i stays low for 'hold' cycles after valid_o
  task automatic run_op(input bit s8, input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string tag);
    int lat, waited;
    @(negedge clk);
    op = o; a = ia; b = ib; rdy = 1'b0;
    if (s8) v8 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; v32 = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!cur_vo(s8) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "/res"}, 64'(cur_res(s8)), 64'(exp));
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (hold < 0) rdy = (waited >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
      else          rdy = (waited >= hold);
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      check({tag, "/hold"}, {31'd0, cur_vo(s8), cur_res(s8)}, {31'd0, 1'b1, exp});
    end
    check({tag, "/ack"}, 64'(cur_vo(s8)), 64'd0);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'(64'd1 << (w - 1));
      3:       return 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic sweep(input bit s8, input int n);
    int          w, lat;
    bit          fast, sp;
    logic [2:0]  o;
    logic [31:0] ia, ib, m, mn, exp;
    w    = s8 ? 8 : 32;
    fast = !s8;
    m    = 32'((64'd1 << w) - 64'd1);
    mn   = 32'(64'd1 << (w - 1));
    for (int i = 0; i < n; i++) begin
      o   = 3'($urandom_range(0, 7));
      ia  = pick(w);
      ib  = pick(w);
      exp = 32'(ref_md(w, o, 64'(ia), 64'(ib)));
      sp  = o[2] && ((ib == 0) || ((o == 3'd4 || o == 3'd6) && ia == mn && ib == m));
      lat = (sp && fast) ? 1 : w + 1;
      run_op(s8, o, ia, ib, exp, lat, -1, s8 ? "rnd8" : "rnd32");
    end
  endtask

  initial begin
    bit seen;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; rdy = 1'b0; v32 = 1'b0; v8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", 64'(rdyo32), 64'd1);
    check("rst/valid", 64'({vo32, vo8}), 64'd0);
    check("rst/busy",  64'({busy32, busy8}), 64'd0);
    check("rst/res",   64'({res32, res8}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // reset asserted mid-multiply
    @(negedge clk); v32 = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6;
    @(posedge clk); #1; v32 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst/valid", 64'(vo32), 64'd0);
    check("midrst/ready", 64'(rdyo32), 64'd1);
    check("midrst/busy",  64'(busy32), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= vo32; end
    check("midrst/noresult", 64'(seen), 64'd0);

    run_op(0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 0, "mul");
    run_op(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu");
    run_op(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0, "mulh");
    run_op(0, 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0, "mulhsu");
    run_op(0, 3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0, "div");
    run_op(0, 3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0, "rem");
    run_op(0, 3'd5, 32'd100,      32'd7,        32'd14,       33, 0, "divu");
    run_op(0, 3'd7, 32'd100,      32'd7,        32'd2,        33, 0, "remu");
    run_op(0, 3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0, "div0");
    run_op(0, 3'd7, 32'd5,        32'd0,        32'd5,        1,  0, "remu0");
    run_op(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0, "divovf");
    run_op(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0, "removf");
    run_op(0, 3'd4, 32'h80000000, 32'd1,        32'h80000000, 33, 0, "divmn1");
    run_op(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, "mulhmn");
    run_op(0, 3'd0, 32'd12345,    32'd6789,     32'd83810205, 33, 10, "backpr");

    run_op(1, 3'd4, 32'h80,       32'hFF,       32'h80,       9,  0, "div8ovf");
    run_op(1, 3'd6, 32'h80,       32'hFF,       32'h00,       9,  0, "rem8ovf");
    run_op(1, 3'd4, 32'd5,        32'd0,        32'hFF,       9,  0, "div8z");
    run_op(1, 3'd6, 32'hFB,       32'd0,        32'hFB,       9,  0, "rem8z");
    run_op(1, 3'd4, 32'h80,       32'd1,        32'h80,       9,  0, "div8mn1");
    run_op(1, 3'd2, 32'hFF,       32'hFF,       32'hFF,       9,  0, "mulhsu8");

    // flush during a divide
    @(negedge clk); v32 = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; v32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush/ready", 64'(rdyo32), 64'd1);
    check("flush/busy",  64'(busy32), 64'd0);
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= vo32; end
    check("flush/noresult", 64'(seen), 64'd0);
    run_op(0, 3'd0, 32'd3, 32'd4, 32'd12, 33, 0, "postflush");

    // flush in IDLE blocks the request
    @(negedge clk); flush = 1'b1; v32 = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    check("idleflush/busy", 64'(busy32), 64'd0);
    v32 = 1'b0; flush = 1'b0;

    sweep(0, 60);
    sweep(1, 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
